// File: rtl/sparc_pkg.sv
// Shared SPARC definitions for the sequencer: Bicc condition encodings, icc bit
// positions, sequencer state encoding and the Bicc condition evaluator.
package sparc_pkg;

   localparam logic [3:0] COND_BN   = 4'h0;
   localparam logic [3:0] COND_BE   = 4'h1;
   localparam logic [3:0] COND_BLE  = 4'h2;
   localparam logic [3:0] COND_BL   = 4'h3;
   localparam logic [3:0] COND_BLEU = 4'h4;
   localparam logic [3:0] COND_BCS  = 4'h5;
   localparam logic [3:0] COND_BNEG = 4'h6;
   localparam logic [3:0] COND_BVS  = 4'h7;
   localparam logic [3:0] COND_BA   = 4'h8;
   localparam logic [3:0] COND_BNE  = 4'h9;
   localparam logic [3:0] COND_BG   = 4'hA;
   localparam logic [3:0] COND_BGE  = 4'hB;
   localparam logic [3:0] COND_BGU  = 4'hC;
   localparam logic [3:0] COND_BCC  = 4'hD;
   localparam logic [3:0] COND_BPOS = 4'hE;
   localparam logic [3:0] COND_BVC  = 4'hF;

   localparam int ICC_N = 3;
   localparam int ICC_Z = 2;
   localparam int ICC_V = 1;
   localparam int ICC_C = 0;

   typedef enum logic [1:0] {
      S_FETCH = 2'd0,
      S_EXEC  = 2'd1,
      S_HALT  = 2'd2
   } seq_state_t;

   function automatic logic cond_eval(input logic [3:0] cond, input logic [3:0] nzvc);
      logic n, z, v, c, r;
      n = nzvc[ICC_N];
      z = nzvc[ICC_Z];
      v = nzvc[ICC_V];
      c = nzvc[ICC_C];
      r = 1'b0;
      case (cond)
         COND_BA:   r = 1'b1;
         COND_BN:   r = 1'b0;
         COND_BNE:  r = !z;
         COND_BE:   r = z;
         COND_BG:   r = !(z | (n ^ v));
         COND_BLE:  r = z | (n ^ v);
         COND_BGE:  r = !(n ^ v);
         COND_BL:   r = n ^ v;
         COND_BGU:  r = !(c | z);
         COND_BLEU: r = c | z;
         COND_BCC:  r = !c;
         COND_BCS:  r = c;
         COND_BPOS: r = !n;
         COND_BNEG: r = n;
         COND_BVC:  r = !v;
         COND_BVS:  r = v;
         default:   r = 1'b0;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/pc_next_calc.sv
// Combinational next PC/nPC/annul computation for a non-annulled instruction
// completing execution. Decode priority is JMPL > CALL > Bicc > sequential.
module pc_next_calc
   import sparc_pkg::*;
#(
   parameter int ADDR_W = 32
) (
   input  logic [ADDR_W-1:0] pc,
   input  logic [ADDR_W-1:0] npc,
   input  logic [3:0]        icc,
   input  logic              is_bicc,
   input  logic              is_call,
   input  logic              is_jmpl,
   input  logic [4:0]        cond_code,
   input  logic [21:0]       disp22,
   input  logic [29:0]       disp30,
   input  logic [ADDR_W-1:0] jmpl_target,
   output logic [ADDR_W-1:0] pc_next,
   output logic [ADDR_W-1:0] npc_next,
   output logic              annul_next,
   output logic              taken,
   output logic              misalign
);

   logic [ADDR_W-1:0] seq_npc;
   logic [ADDR_W-1:0] bicc_target;
   logic [ADDR_W-1:0] call_target;
   logic              cond_true;

   // Word displacements are sign-extended; all sums wrap modulo 2^ADDR_W.
   assign seq_npc     = npc + ADDR_W'(4);
   assign bicc_target = pc + ADDR_W'($signed({disp22, 2'b00}));
   assign call_target = pc + ADDR_W'($signed({disp30, 2'b00}));
   assign cond_true   = cond_eval(cond_code[3:0], icc);

   always_comb begin
      pc_next    = npc;
      npc_next   = seq_npc;
      annul_next = 1'b0;
      taken      = 1'b0;
      misalign   = 1'b0;
      if (is_jmpl) begin
         if (jmpl_target[1:0] != 2'b00) begin
            misalign = 1'b1;
            pc_next  = pc;
            npc_next = npc;
         end else begin
            npc_next = jmpl_target;
            taken    = 1'b1;
         end
      end else if (is_call) begin
         npc_next = call_target;
         taken    = 1'b1;
      end else if (is_bicc) begin
         taken = cond_true;
         if (cond_true) begin
            npc_next = bicc_target;
         end
         // BA,a annuls its slot even though taken; other a=1 branches annul only when untaken.
         annul_next = cond_code[4] & (!cond_true | (cond_code[3:0] == COND_BA));
      end
   end

endmodule

// File: rtl/branch_sequencer.sv
// Owns PC/nPC and icc; walks each instruction through fetch and execute, applying
// Bicc/CALL/JMPL redirects with SPARC delayed-branch annul semantics.
module branch_sequencer
   import sparc_pkg::*;
#(
   parameter int                ADDR_W   = 32,
   parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
   input  logic              clk,
   input  logic              reset,
   output logic              fetch_req,
   output logic [ADDR_W-1:0] fetch_addr,
   input  logic              fetch_ack,
   input  logic              is_bicc,
   input  logic [4:0]        cond_code,
   input  logic [21:0]       disp22,
   input  logic              is_call,
   input  logic [29:0]       disp30,
   input  logic              is_jmpl,
   input  logic [ADDR_W-1:0] jmpl_target,
   input  logic              exec_done,
   input  logic              cc_we,
   input  logic [3:0]        alu_nzvc,
   output logic [ADDR_W-1:0] pc,
   output logic [ADDR_W-1:0] npc,
   output logic [3:0]        icc,
   output logic              exec_en,
   output logic              branch_taken,
   output logic              misalign
);

   seq_state_t        state_reg, state_next;
   logic [ADDR_W-1:0] pc_reg, pc_next;
   logic [ADDR_W-1:0] npc_reg, npc_next;
   logic [3:0]        icc_reg, icc_next;
   logic              annul_reg, annul_next;
   logic              taken_reg, taken_next;
   logic              misalign_reg, misalign_next;
   logic              dec_bicc_reg, dec_bicc_next;
   logic              dec_call_reg, dec_call_next;
   logic              dec_jmpl_reg, dec_jmpl_next;
   logic [4:0]        dec_cond_reg, dec_cond_next;
   logic [21:0]       dec_disp22_reg, dec_disp22_next;
   logic [29:0]       dec_disp30_reg, dec_disp30_next;

   logic [ADDR_W-1:0] calc_pc, calc_npc;
   logic              calc_annul, calc_taken, calc_misalign;

   pc_next_calc #(.ADDR_W(ADDR_W)) u_pc_next_calc (
      .pc          (pc_reg),
      .npc         (npc_reg),
      .icc         (icc_reg),
      .is_bicc     (dec_bicc_reg),
      .is_call     (dec_call_reg),
      .is_jmpl     (dec_jmpl_reg),
      .cond_code   (dec_cond_reg),
      .disp22      (dec_disp22_reg),
      .disp30      (dec_disp30_reg),
      .jmpl_target (jmpl_target),
      .pc_next     (calc_pc),
      .npc_next    (calc_npc),
      .annul_next  (calc_annul),
      .taken       (calc_taken),
      .misalign    (calc_misalign)
   );

   always_comb begin
      state_next      = state_reg;
      pc_next         = pc_reg;
      npc_next        = npc_reg;
      icc_next        = icc_reg;
      annul_next      = annul_reg;
      taken_next      = 1'b0;
      misalign_next   = misalign_reg;
      dec_bicc_next   = dec_bicc_reg;
      dec_call_next   = dec_call_reg;
      dec_jmpl_next   = dec_jmpl_reg;
      dec_cond_next   = dec_cond_reg;
      dec_disp22_next = dec_disp22_reg;
      dec_disp30_next = dec_disp30_reg;
      fetch_req       = 1'b0;
      exec_en         = 1'b0;
      case (state_reg)
         S_FETCH: begin
            fetch_req = 1'b1;
            if (fetch_ack) begin
               dec_bicc_next   = is_bicc;
               dec_call_next   = is_call;
               dec_jmpl_next   = is_jmpl;
               dec_cond_next   = cond_code;
               dec_disp22_next = disp22;
               dec_disp30_next = disp30;
               state_next      = S_EXEC;
            end
         end
         S_EXEC: begin
            if (annul_reg) begin
               // Annulled delay slot: skip it in one cycle, exec_done is ignored.
               annul_next = 1'b0;
               pc_next    = npc_reg;
               npc_next   = npc_reg + ADDR_W'(4);
               state_next = S_FETCH;
            end else begin
               exec_en = 1'b1;
               if (exec_done) begin
                  if (cc_we) begin
                     icc_next = alu_nzvc;
                  end
                  if (calc_misalign) begin
                     misalign_next = 1'b1;
                     state_next    = S_HALT;
                  end else begin
                     pc_next    = calc_pc;
                     npc_next   = calc_npc;
                     annul_next = calc_annul;
                     taken_next = calc_taken;
                     state_next = S_FETCH;
                  end
               end
            end
         end
         S_HALT: begin
            state_next = S_HALT;
         end
         default: begin
            state_next = S_FETCH;
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_reg      <= S_FETCH;
         pc_reg         <= RESET_PC;
         npc_reg        <= RESET_PC + ADDR_W'(4);
         icc_reg        <= '0;
         annul_reg      <= 1'b0;
         taken_reg      <= 1'b0;
         misalign_reg   <= 1'b0;
         dec_bicc_reg   <= 1'b0;
         dec_call_reg   <= 1'b0;
         dec_jmpl_reg   <= 1'b0;
         dec_cond_reg   <= '0;
         dec_disp22_reg <= '0;
         dec_disp30_reg <= '0;
      end else begin
         state_reg      <= state_next;
         pc_reg         <= pc_next;
         npc_reg        <= npc_next;
         icc_reg        <= icc_next;
         annul_reg      <= annul_next;
         taken_reg      <= taken_next;
         misalign_reg   <= misalign_next;
         dec_bicc_reg   <= dec_bicc_next;
         dec_call_reg   <= dec_call_next;
         dec_jmpl_reg   <= dec_jmpl_next;
         dec_cond_reg   <= dec_cond_next;
         dec_disp22_reg <= dec_disp22_next;
         dec_disp30_reg <= dec_disp30_next;
      end
   end

   assign fetch_addr   = pc_reg;
   assign pc           = pc_reg;
   assign npc          = npc_reg;
   assign icc          = icc_reg;
   assign branch_taken = taken_reg;
   assign misalign     = misalign_reg;

endmodule

// File: tb/tb_branch_sequencer.sv
// Randomized self-checking bench for branch_sequencer against an instruction-level
// reference model of PC/nPC/icc/annul behaviour.
module tb_branch_sequencer;

   localparam int AW = 32;

   logic          clk = 1'b0;
   logic          reset;
   logic          fetch_req;
   logic [AW-1:0] fetch_addr;
   logic          fetch_ack;
   logic          is_bicc;
   logic [4:0]    cond_code;
   logic [21:0]   disp22;
   logic          is_call;
   logic [29:0]   disp30;
   logic          is_jmpl;
   logic [AW-1:0] jmpl_target;
   logic          exec_done;
   logic          cc_we;
   logic [3:0]    alu_nzvc;
   logic [AW-1:0] pc;
   logic [AW-1:0] npc;
   logic [3:0]    icc;
   logic          exec_en;
   logic          branch_taken;
   logic          misalign;

   int n_cmp = 0;
   int n_bad = 0;

   logic [31:0] m_pc, m_npc;
   logic [3:0]  m_icc;
   bit          m_annul, m_halt, m_mis;

   branch_sequencer #(.ADDR_W(AW), .RESET_PC(32'h0000_0000)) dut (
      .clk          (clk),
      .reset        (reset),
      .fetch_req    (fetch_req),
      .fetch_addr   (fetch_addr),
      .fetch_ack    (fetch_ack),
      .is_bicc      (is_bicc),
      .cond_code    (cond_code),
      .disp22       (disp22),
      .is_call      (is_call),
      .disp30       (disp30),
      .is_jmpl      (is_jmpl),
      .jmpl_target  (jmpl_target),
      .exec_done    (exec_done),
      .cc_we        (cc_we),
      .alu_nzvc     (alu_nzvc),
      .pc           (pc),
      .npc          (npc),
      .icc          (icc),
      .exec_en      (exec_en),
      .branch_taken (branch_taken),
      .misalign     (misalign)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Conditions come in complementary pairs: cond[3] inverts the base relation.
   function automatic bit ref_cond(input logic [3:0] c, input logic [3:0] f);
      bit n, z, v, cy, base;
      n = f[3]; z = f[2]; v = f[1]; cy = f[0];
      case (c[2:0])
         3'd0:    base = 1'b0;
         3'd1:    base = z;
         3'd2:    base = z | (n ^ v);
         3'd3:    base = n ^ v;
         3'd4:    base = cy | z;
         3'd5:    base = cy;
         3'd6:    base = n;
         default: base = v;
      endcase
      return base ^ c[3];
   endfunction

   task automatic clear_inputs();
      fetch_ack = 0; is_bicc = 0; cond_code = 0; disp22 = 0; is_call = 0;
      disp30 = 0; is_jmpl = 0; jmpl_target = 0; exec_done = 0; cc_we = 0; alu_nzvc = 0;
   endtask

   task automatic do_reset();
      clear_inputs();
      reset = 1'b1;
      tick();
      tick();
      reset = 1'b0;
      m_pc = 32'h0; m_npc = 32'h4; m_icc = 4'h0;
      m_annul = 0; m_halt = 0; m_mis = 0;
   endtask

   task automatic do_instr(input bit f_bicc, input bit f_call, input bit f_jmpl,
                           input logic [4:0] cc5, input logic [21:0] d22,
                           input logic [29:0] d30, input logic [31:0] tgt,
                           input bit cwe, input logic [3:0] nz, input string tag);
      int w;
      bit exp_taken, t;
      logic [31:0] pc_old, npc_old;
      logic [3:0] icc_old;
      bit was_annul;
      w = $urandom_range(0, 2);
      for (int i = 0; i <= w; i++) begin
         n_cmp++;
         if (fetch_req !== 1'b1 || fetch_addr !== m_pc) begin
            n_bad++;
            $display("FAIL %s fetch: req=%b addr=%h expected req=1 addr=%h", tag, fetch_req, fetch_addr, m_pc);
         end
         if (i < w) begin
            exec_done = 1'($urandom_range(0, 1)); cc_we = 1'b1; alu_nzvc = 4'($urandom);
            tick();
         end
      end
      exec_done = 0; cc_we = 0;
      fetch_ack = 1; is_bicc = f_bicc; is_call = f_call; is_jmpl = f_jmpl;
      cond_code = cc5; disp22 = d22; disp30 = d30;
      tick();
      fetch_ack = 0;
      is_bicc = 1'($urandom); is_call = 1'($urandom); is_jmpl = 1'($urandom);
      cond_code = 5'($urandom); disp22 = 22'($urandom); disp30 = 30'($urandom);
      n_cmp++;
      if (branch_taken !== 1'b0) begin
         n_bad++;
         $display("FAIL %s taken_pulse_width: branch_taken=%b expected 0", tag, branch_taken);
      end
      was_annul = m_annul;
      exp_taken = 0;
      if (m_annul) begin
         n_cmp++;
         if (exec_en !== 1'b0) begin
            n_bad++;
            $display("FAIL %s annul_exec_en: exec_en=%b expected 0", tag, exec_en);
         end
         exec_done = 1; cc_we = 1; alu_nzvc = ~m_icc;
         tick();
         exec_done = 0; cc_we = 0;
         m_pc = m_npc; m_npc = m_npc + 32'd4; m_annul = 0;
      end else begin
         w = $urandom_range(0, 3);
         for (int i = 0; i < w; i++) begin
            n_cmp++;
            if (exec_en !== 1'b1 || pc !== m_pc) begin
               n_bad++;
               $display("FAIL %s exec_wait: exec_en=%b pc=%h expected exec_en=1 pc=%h", tag, exec_en, pc, m_pc);
            end
            fetch_ack = 1'($urandom_range(0, 1));
            tick();
            fetch_ack = 0;
         end
         n_cmp++;
         if (exec_en !== 1'b1) begin
            n_bad++;
            $display("FAIL %s exec_en: exec_en=%b expected 1", tag, exec_en);
         end
         exec_done = 1; cc_we = cwe; alu_nzvc = nz; jmpl_target = tgt;
         tick();
         exec_done = 0; cc_we = 0; jmpl_target = $urandom;
         pc_old = m_pc; npc_old = m_npc; icc_old = m_icc;
         if (cwe) m_icc = nz;
         if (f_jmpl) begin
            if (tgt[1:0] != 2'b00) begin
               m_mis = 1; m_halt = 1;
            end else begin
               m_pc = npc_old; m_npc = tgt; exp_taken = 1;
            end
         end else if (f_call) begin
            m_pc = npc_old; m_npc = pc_old + {d30, 2'b00}; exp_taken = 1;
         end else if (f_bicc) begin
            t = ref_cond(cc5[3:0], icc_old);
            m_pc = npc_old;
            m_npc = t ? pc_old + {{8{d22[21]}}, d22, 2'b00} : npc_old + 32'd4;
            m_annul = cc5[4] && (!t || cc5[3:0] == 4'b1000);
            exp_taken = t;
         end else begin
            m_pc = npc_old; m_npc = npc_old + 32'd4;
         end
      end
      n_cmp++;
      if (pc !== m_pc || npc !== m_npc || icc !== m_icc) begin
         n_bad++;
         $display("FAIL %s state: pc=%h npc=%h icc=%h expected pc=%h npc=%h icc=%h",
                  tag, pc, npc, icc, m_pc, m_npc, m_icc);
      end
      n_cmp++;
      if (branch_taken !== exp_taken || misalign !== m_mis || fetch_req !== !m_halt || exec_en !== 1'b0) begin
         n_bad++;
         $display("FAIL %s flags: taken=%b misalign=%b fetch_req=%b exec_en=%b expected %b %b %b 0",
                  tag, branch_taken, misalign, fetch_req, exec_en, exp_taken, m_mis, !m_halt);
      end
      $display("%s: annulled=%0b pc=%h npc=%h icc=%h taken=%0b", tag, was_annul, pc, npc, icc, branch_taken);
   endtask

   task automatic plain(input string tag);
      do_instr(0, 0, 0, 5'd0, 22'd0, 30'd0, 32'd0, 0, 4'd0, tag);
   endtask

   task automatic test_reset();
      do_reset();
      n_cmp++;
      if (pc !== 32'h0 || npc !== 32'h4 || icc !== 4'h0 || fetch_req !== 1'b1 || fetch_addr !== 32'h0 ||
          exec_en !== 1'b0 || branch_taken !== 1'b0 || misalign !== 1'b0) begin
         n_bad++;
         $display("FAIL reset_state: pc=%h npc=%h icc=%h req=%b addr=%h en=%b tk=%b mis=%b expected 0 4 0 1 0 0 0 0",
                  pc, npc, icc, fetch_req, fetch_addr, exec_en, branch_taken, misalign);
      end
      $display("reset: pc=%h npc=%h icc=%h", pc, npc, icc);
   endtask

   task automatic test_sequential();
      plain("seq0");
      plain("seq1");
      plain("seq2");
   endtask

   task automatic test_branch_taken();
      do_reset();
      plain("pre0");
      do_instr(0, 0, 0, 5'd0, 22'd0, 30'd0, 32'd0, 1, 4'b0100, "set_z");
      do_instr(1, 0, 0, 5'b00001, 22'd4, 30'd0, 32'd0, 0, 4'd0, "be_taken");
      plain("be_slot");
      plain("be_target");
   endtask

   task automatic test_annul_not_taken();
      do_instr(0, 0, 1, 5'd0, 22'd0, 30'd0, 32'h20, 0, 4'd0, "jmpl_20");
      plain("jmpl_slot");
      do_instr(1, 0, 0, 5'b11001, 22'd8, 30'd0, 32'd0, 0, 4'd0, "bne_a");
      plain("bne_annulled");
      plain("after_bne");
   endtask

   task automatic test_ba_annul();
      do_instr(0, 0, 1, 5'd0, 22'd0, 30'd0, 32'h40, 0, 4'd0, "jmpl_40");
      plain("jmpl_slot");
      do_instr(1, 0, 0, 5'b11000, 22'h3FFFFE, 30'd0, 32'd0, 0, 4'd0, "ba_a");
      plain("ba_annulled");
      plain("ba_target");
   endtask

   task automatic test_call_wrap();
      do_instr(0, 1, 0, 5'd0, 22'd0, 30'h3FFFFFF0, 32'd0, 0, 4'd0, "call_neg");
      plain("call_slot");
      do_instr(0, 1, 1, 5'd0, 22'd0, 30'd5, 32'h80, 0, 4'd0, "prio_jmpl");
      plain("prio_slot");
   endtask

   task automatic test_random();
      int r;
      bit fb, fc, fj;
      for (int k = 0; k < 150; k++) begin
         r = $urandom_range(0, 9);
         fb = (r >= 4 && r <= 6); fc = (r == 7); fj = (r == 8);
         if (r == 9) begin
            fb = 1'($urandom); fc = 1'($urandom); fj = 1'($urandom);
         end
         do_instr(fb, fc, fj, 5'($urandom), 22'($urandom), 30'($urandom),
                  {30'($urandom), 2'b00}, 1'($urandom), 4'($urandom), "rand");
      end
   endtask

   task automatic test_jmpl();
      do_instr(0, 0, 1, 5'd0, 22'd0, 30'd0, 32'h100, 0, 4'd0, "jmpl_100");
      plain("jmpl_slot");
      do_instr(0, 0, 1, 5'd0, 22'd0, 30'd0, 32'h102, 0, 4'd0, "jmpl_102");
      for (int i = 0; i < 5; i++) begin
         fetch_ack = 1; exec_done = 1; cc_we = 1; alu_nzvc = 4'hF;
         tick();
         n_cmp++;
         if (fetch_req !== 1'b0 || exec_en !== 1'b0 || misalign !== 1'b1 || pc !== m_pc || icc !== m_icc) begin
            n_bad++;
            $display("FAIL halt_hold: req=%b en=%b mis=%b pc=%h icc=%h expected 0 0 1 %h %h",
                     fetch_req, exec_en, misalign, pc, icc, m_pc, m_icc);
         end
      end
      clear_inputs();
      $display("halt: pc=%h misalign=%b", pc, misalign);
   endtask

   task automatic test_reset_mid_exec();
      do_reset();
      do_instr(0, 0, 0, 5'd0, 22'd0, 30'd0, 32'd0, 1, 4'hF, "set_icc");
      plain("adv");
      fetch_ack = 1;
      tick();
      fetch_ack = 0;
      cc_we = 1; alu_nzvc = 4'hA;
      tick();
      reset = 1'b1;
      #1;
      n_cmp++;
      if (pc !== 32'h0 || npc !== 32'h4 || icc !== 4'h0) begin
         n_bad++;
         $display("FAIL async_reset: pc=%h npc=%h icc=%h expected 0 4 0", pc, npc, icc);
      end
      exec_done = 1;
      tick();
      exec_done = 0; cc_we = 0;
      reset = 1'b0;
      tick();
      n_cmp++;
      if (fetch_req !== 1'b1 || fetch_addr !== 32'h0 || icc !== 4'h0 || exec_en !== 1'b0) begin
         n_bad++;
         $display("FAIL reset_release: req=%b addr=%h icc=%h en=%b expected 1 0 0 0", fetch_req, fetch_addr, icc, exec_en);
      end
      $display("mid_exec_reset: pc=%h icc=%h fetch_req=%b", pc, icc, fetch_req);
      m_pc = 32'h0; m_npc = 32'h4; m_icc = 4'h0; m_annul = 0; m_halt = 0; m_mis = 0;
      plain("post_reset");
   endtask

   initial begin
      reset = 1'b1;
      clear_inputs();
      test_reset();
      test_sequential();
      test_branch_taken();
      test_annul_not_taken();
      test_ba_annul();
      test_call_wrap();
      test_random();
      test_jmpl();
      test_reset_mid_exec();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
